mem_arbiter: RTL and testbench

//  Shares one single-port backing memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares a single-port req/ack backing memory between the
//                instruction-fetch port and the load/store port. One
//                transaction outstanding at a time; data wins ties unless IF
//                has been starved for STARVE_MAX consecutive data grants.
//  Options     : MEM_ARB_TIMEOUT_EN - abort a transaction after TIMEOUT busy
//                cycles without mem_ack, return 32'hDEADBEEF, set sticky err.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int D_WIDTH    = 32,
   parameter int A_WIDTH    = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [A_WIDTH-1:0] if_addr,
   output logic               if_gnt,
   output logic               if_rvalid,
   output logic [D_WIDTH-1:0] if_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [A_WIDTH-1:0] d_addr,
   input  logic [D_WIDTH-1:0] d_wdata,
   output logic               d_gnt,
   output logic               d_rvalid,
   output logic [D_WIDTH-1:0] d_rdata,
   output logic               mem_req,
   output logic               mem_we,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic [D_WIDTH-1:0] mem_wdata,
   input  logic               mem_ack,
   input  logic [D_WIDTH-1:0] mem_rdata,
   output logic               busy,
   output logic               err
);

   localparam int            SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               grant_d;
   logic               grant_if;
   logic               finish;
   logic               tmo;
   logic [D_WIDTH-1:0] finish_data;
   logic [SW-1:0]      starve_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration in IDLE; completion (ack or abort) in the busy states
   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_if  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            // Data drains first so a load-use stall resolves, unless IF has
            // already lost STARVE_MAX grants in a row.
            if (d_req && ((starve_cnt < STARVE_LIM) || !if_req)) begin
               grant_d   = 1'b1;
               state_nxt = D_BUSY;
            end else if (if_req) begin
               grant_if  = 1'b1;
               state_nxt = IF_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (mem_ack || tmo) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Request capture onto the memory bus, grant/valid pulses, read-data return
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_gnt     <= 1'b0;
         d_gnt      <= 1'b0;
         if_rvalid  <= 1'b0;
         d_rvalid   <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         starve_cnt <= '0;
      end else begin
         if_gnt    <= grant_if;
         d_gnt     <= grant_d;
         if_rvalid <= finish && (state == IF_BUSY);
         d_rvalid  <= finish && (state == D_BUSY);
         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req) begin
               starve_cnt <= '0;
            end else if (starve_cnt < STARVE_LIM) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else if (grant_if) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
         end else if (finish) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == IF_BUSY) begin
               if_rdata <= finish_data;
            end else if (!mem_we || tmo) begin
               // A completed store leaves the last load data in place
               d_rdata <= finish_data;
            end
         end
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int                TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [D_WIDTH-1:0] ABORT_DATA = D_WIDTH'(32'hDEADBEEF);

   logic [TW-1:0] tmo_cnt;
   logic          err_r;

   // Busy-cycle counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt <= '0;
         err_r   <= 1'b0;
      end else begin
         if (state == IDLE) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo) begin
            err_r <= 1'b1;
         end
      end
   end

   // Abort wins over an ack arriving in the same cycle
   assign tmo         = (state != IDLE) && (tmo_cnt == TMO_LAST);
   assign err         = err_r;
   assign finish_data = tmo ? ABORT_DATA : mem_rdata;
`else
   // TIMEOUT has no effect without the abort logic
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo            = 1'b0;
   assign err            = 1'b0;
   assign finish_data    = mem_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A transaction-level
//                reference model predicts grants, completions and bus contents;
//                a scoreboard queue carries expected read data to a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   localparam int SMAX = 4;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack   = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(
      .D_WIDTH   (32),
      .A_WIDTH   (32),
      .STARVE_MAX(SMAX),
      .TIMEOUT   (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   // Memory contents: physical (written through the DUT bus) and reference
   logic [31:0] phys [logic [31:0]];
   logic [31:0] refm [logic [31:0]];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   function automatic logic [31:0] rd_phys(input logic [31:0] a);
      return phys.exists(a) ? phys[a] : init_val(a);
   endfunction

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      return refm.exists(a) ? refm[a] : init_val(a);
   endfunction

   // Variable-latency memory responder
   bit mem_hold  = 1'b0;
   int fixed_lat = -1;
   int lat       = 0;
   bit lat_set   = 1'b0;

   always @(negedge clk) begin
      if (mem_ack) begin
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
      end else if (mem_req === 1'b1 && !mem_hold) begin
         if (!lat_set) begin
            lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            lat_set = 1'b1;
         end
         if (lat == 0) begin
            mem_ack = 1'b1;
            lat_set = 1'b0;
            if (mem_we) phys[mem_addr] = mem_wdata;
            else        mem_rdata      = rd_phys(mem_addr);
         end else begin
            lat--;
         end
      end else if (mem_req !== 1'b1) begin
         lat_set = 1'b0;
      end
   end

   // Reference model and scoreboard
   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        scb[$];
   int          m_port   = 0;   // 0 none, 1 fetch, 2 data
   int          m_starve = 0;
   int          m_bc     = 0;
   bit          m_err    = 1'b0;
   bit          m_we     = 1'b0;
   logic [31:0] m_addr   = 32'h0;
   logic [31:0] m_wdata  = 32'h0;
   logic [31:0] m_last_d = 32'h0;

   always @(posedge clk) begin
      bit   e_ifg, e_dg, e_ifv, e_dv;
      exp_t e;
      #2;
      e_ifg = 1'b0; e_dg = 1'b0; e_ifv = 1'b0; e_dv = 1'b0;
      if (!rst) begin
         m_port = 0; m_starve = 0; m_err = 1'b0; m_last_d = 32'h0;
         scb.delete();
         chk("rst_if_rdata", if_rdata, 32'h0);
         chk("rst_d_rdata", d_rdata, 32'h0);
      end else if (m_port == 0) begin
         if (d_req && (m_starve < SMAX || !if_req)) begin
            e_dg = 1'b1; m_port = 2; m_bc = 1;
            m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
            m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
            e.is_d = 1'b1;
            if (d_we) begin
               refm[d_addr] = d_wdata;
               e.data = m_last_d;
            end else begin
               e.data   = rd_ref(d_addr);
               m_last_d = e.data;
            end
            scb.push_back(e);
         end else if (if_req) begin
            e_ifg = 1'b1; m_port = 1; m_bc = 1; m_starve = 0;
            m_addr = if_addr; m_we = 1'b0; m_wdata = 32'h0;
            e.is_d = 1'b0;
            e.data = rd_ref(if_addr);
            scb.push_back(e);
         end
      end else begin
`ifdef MEM_ARB_TIMEOUT_EN
         if (m_bc == TMO) begin
            if (m_port == 1) e_ifv = 1'b1; else e_dv = 1'b1;
            if (m_port == 2) m_last_d = 32'hDEADBEEF;
            m_err = 1'b1;
            m_port = 0;
            if (scb.size() > 0) begin
               e = scb.pop_back();
               e.data = 32'hDEADBEEF;
               scb.push_back(e);
            end
         end else
`endif
         if (mem_ack) begin
            if (m_port == 1) e_ifv = 1'b1; else e_dv = 1'b1;
            m_port = 0;
         end else begin
            m_bc++;
         end
      end
      chk1("if_gnt", if_gnt, e_ifg);
      chk1("d_gnt", d_gnt, e_dg);
      chk1("if_rvalid", if_rvalid, e_ifv);
      chk1("d_rvalid", d_rvalid, e_dv);
      chk1("busy", busy, m_port != 0);
      chk1("mem_req", mem_req, m_port != 0);
      chk1("err", err, m_err);
      if (m_port != 0) begin
         chk("mem_addr", mem_addr, m_addr);
         chk1("mem_we", mem_we, m_we);
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
   end

   // Monitor: pops the scoreboard on every returned response
   always @(negedge clk) begin
      exp_t t;
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
         if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scb_unexpected_rvalid actual if=%b d=%b expected none", if_rvalid, d_rvalid);
         end else begin
            t = scb.pop_front();
            chk1("rvalid_port_d", d_rvalid, t.is_d);
            chk1("rvalid_port_if", if_rvalid, !t.is_d);
            if (t.is_d) chk("scb_d_rdata", d_rdata, t.data);
            else        chk("scb_if_rdata", if_rdata, t.data);
         end
      end
   end

   // Issue one request, wait for its grant and its response (bounded)
   task automatic issue(input bit is_d, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, output int gl, output int rl);
      @(negedge clk);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      gl = 0;
      do begin @(negedge clk); gl++; end while (!(is_d ? d_gnt : if_gnt) && gl < 40);
      d_req = 1'b0; if_req = 1'b0;
      rl = 0;
      do begin @(negedge clk); rl++; end while (!(is_d ? d_rvalid : if_rvalid) && rl < 40);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (busy && n < 60) begin @(negedge clk); n++; end
      chk1("drain_idle", busy, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int gl, rl, n, g, code, exp_code;
      rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk1("reset_busy", busy, 1'b0);

      // Fetch with a two-cycle memory
      phys[32'h10] = 32'h00500093;
      refm[32'h10] = 32'h00500093;
      fixed_lat = 2;
      issue(1'b0, 1'b0, 32'h10, 32'h0, gl, rl);
      chk("t2_gnt_latency", gl, 1);
      chk("t2_rvalid_latency", rl, 3);
      chk("t2_if_rdata", if_rdata, 32'h00500093);
      drain();

      // Simultaneous requests: data first, then fetch
      fixed_lat = 0;
      @(negedge clk);
      if_addr = 32'h14; d_addr = 32'h80; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      code = 0; n = 0;
      while ((if_req || d_req || busy) && n < 40) begin
         @(negedge clk); n++;
         if (d_gnt)  begin d_req = 1'b0;  code = code * 4 + 1; end
         if (if_gnt) begin if_req = 1'b0; code = code * 4 + 2; end
      end
      chk("t3_grant_order", code, 6);
      drain();

      // Reset in the middle of a transaction
      mem_hold = 1'b1;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      n = 0;
      do begin @(negedge clk); n++; end while (!d_gnt && n < 40);
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mem_hold = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk1("t1_no_late_rvalid", if_rvalid | d_rvalid, 1'b0);
      end
      chk1("t1_busy", busy, 1'b0);
      chk1("t1_mem_req", mem_req, 1'b0);

      // Starvation limit with both requesters held high
      fixed_lat = -1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_code = 0;
      for (int k = 0; k < 6; k++) exp_code = exp_code * 4 + ((k == SMAX) ? 2 : 1);
      if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
      code = 0; g = 0; n = 0;
      while (g < 6 && n < 100) begin
         @(negedge clk); n++;
         if (d_gnt)  begin code = code * 4 + 1; g++; d_addr  = $urandom_range(0, 15) * 4; end
         if (if_gnt) begin code = code * 4 + 2; g++; if_addr = $urandom_range(0, 31) * 4; end
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("t4_grant_order", code, exp_code);
      drain();

      // Store then load back
      fixed_lat = 3;
      issue(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, gl, rl);
      chk("t5_store_gnt_latency", gl, 1);
      chk("t5_store_rvalid_latency", rl, 4);
      fixed_lat = 1;
      issue(1'b1, 1'b0, 32'h40, 32'h0, gl, rl);
      chk("t5_load_back", d_rdata, 32'hCAFEF00D);
      drain();

      // Memory that never answers
      fixed_lat = 0;
      mem_hold = 1'b1;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h200;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_gnt && n < 40);
      if_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      rl = 0;
      do begin @(negedge clk); rl++; end while (!if_rvalid && rl < 40);
      chk("t6_abort_latency", rl, TMO);
      chk("t6_abort_data", if_rdata, 32'hDEADBEEF);
      chk1("t6_err", err, 1'b1);
      mem_hold = 1'b0;
      repeat (3) @(negedge clk);
      chk1("t6_err_sticky", err, 1'b1);
`else
      repeat (20) @(negedge clk);
      chk1("t6_still_busy", busy, 1'b1);
      mem_hold = 1'b0;
      rl = 0;
      do begin @(negedge clk); rl++; end while (!if_rvalid && rl < 40);
      chk1("t6_late_rvalid", if_rvalid, 1'b1);
`endif
      drain();

      // Randomized traffic
      fixed_lat = -1;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (if_gnt) if_req = 1'b0;
         if (d_gnt)  d_req  = 1'b0;
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom_range(0, 31) * 4;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom_range(0, 15) * 4; d_wdata = $urandom;
         end
      end
      n = 0;
      while ((if_req || d_req) && n < 60) begin
         @(negedge clk); n++;
         if (if_gnt) if_req = 1'b0;
         if (d_gnt)  d_req  = 1'b0;
      end
      drain();
      chk("scb_drained", scb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
